// File: rtl/hack_cpu_ctrl_if.sv
// Bus between the Hack CPU controller and its instruction ROM / register-memory block.
// The master side (controller) drives the ROM address, the write data and the A/D/M write enables.
interface hack_cpu_ctrl_if #(
    parameter int PC_W   = 15,
    parameter int DATA_W = 16
);
    logic [PC_W-1:0]   rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] reg_a_in;
    logic [DATA_W-1:0] reg_d_in;
    logic [DATA_W-1:0] reg_m_in;
    logic [DATA_W-1:0] data_out;
    logic              reg_a_en;
    logic              reg_d_en;
    logic              reg_m_en;

    modport master (
        output rom_addr, data_out, reg_a_en, reg_d_en, reg_m_en,
        input  rom_data, reg_a_in, reg_d_in, reg_m_in
    );

    modport slave (
        input  rom_addr, data_out, reg_a_en, reg_d_en, reg_m_en,
        output rom_data, reg_a_in, reg_d_in, reg_m_in
    );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// Two-cycle (FETCH/EXEC) controller for a 16-bit Hack-style CPU.
// Optional self-jump halt detection is enabled by defining HACK_CPU_HALT_DETECT_EN.
module hack_cpu_ctrl #(
    parameter int PC_W   = 15,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    hack_cpu_ctrl_if.master     bus,
    output logic [PC_W-1:0]     pc,
    output logic                retire,
    output logic                halted
);

`ifdef HACK_CPU_HALT_DETECT_EN
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1} state_t;
`endif

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   pc_next;

    logic [DATA_W-1:0] instr;
    logic              is_c;
    logic [DATA_W-1:0] alu_x, alu_y, x_z, y_z, x_n, y_n, alu_r, alu_out;
    logic              flag_lt, flag_eq, flag_gt, take;
    logic [PC_W-1:0]   pc_inc, pc_target;

    assign instr = bus.rom_data;
    assign is_c  = instr[15];

    // ALU: zero/negate each operand, add or AND, optionally negate the result.
    assign alu_x   = bus.reg_d_in;
    assign alu_y   = instr[12] ? bus.reg_m_in : bus.reg_a_in;
    assign x_z     = instr[11] ? '0 : alu_x;
    assign x_n     = instr[10] ? ~x_z : x_z;
    assign y_z     = instr[9]  ? '0 : alu_y;
    assign y_n     = instr[8]  ? ~y_z : y_z;
    assign alu_r   = instr[7]  ? (x_n + y_n) : (x_n & y_n);
    assign alu_out = instr[6]  ? ~alu_r : alu_r;

    assign flag_lt = alu_out[DATA_W-1];
    assign flag_eq = (alu_out == '0);
    assign flag_gt = ~flag_lt & ~flag_eq;
    assign take    = is_c & ((instr[2] & flag_lt) | (instr[1] & flag_eq) | (instr[0] & flag_gt));

    // Jump target is the pre-update A; any A write lands at the same edge.
    assign pc_inc    = pc + PC_W'(1);
    assign pc_target = take ? bus.reg_a_in[PC_W-1:0] : pc_inc;

`ifdef HACK_CPU_HALT_DETECT_EN
    logic halted_reg, halted_next, self_jump;
    assign self_jump = take && (bus.reg_a_in[PC_W-1:0] == pc);
    assign halted    = halted_reg;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_FETCH;
            pc         <= '0;
`ifdef HACK_CPU_HALT_DETECT_EN
            halted_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            pc         <= pc_next;
`ifdef HACK_CPU_HALT_DETECT_EN
            halted_reg <= halted_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc;
`ifdef HACK_CPU_HALT_DETECT_EN
        halted_next = halted_reg;
`endif
        case (state_reg)
            S_FETCH: if (run) state_next = S_EXEC;
            S_EXEC: begin
                state_next = S_FETCH;
                pc_next    = pc_target;
`ifdef HACK_CPU_HALT_DETECT_EN
                if (self_jump) begin
                    state_next  = S_HALT;
                    halted_next = 1'b1;
                end
`endif
            end
            default: state_next = state_reg;
        endcase
    end

    // Every write-side output is qualified by EXEC, so reset silences them immediately.
    always_comb begin
        bus.rom_addr = pc;
        bus.data_out = '0;
        bus.reg_a_en = 1'b0;
        bus.reg_d_en = 1'b0;
        bus.reg_m_en = 1'b0;
        retire       = 1'b0;
        if (state_reg == S_EXEC) begin
            retire = 1'b1;
            if (is_c) begin
                bus.data_out = alu_out;
                bus.reg_a_en = instr[5];
                bus.reg_d_en = instr[4];
                bus.reg_m_en = instr[3];
            end else begin
                bus.data_out = {1'b0, instr[DATA_W-2:0]};
                bus.reg_a_en = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: behavioural ROM and A/D/M register-memory around the DUT,
// directed program steps plus random instructions checked against a reference model.
module tb_hack_cpu_ctrl;
    logic        clk;
    logic        rst_n;
    logic        run;
    logic [14:0] pc;
    logic        retire;
    logic        halted;

    hack_cpu_ctrl_if #(.PC_W(15), .DATA_W(16)) bus ();

    hack_cpu_ctrl #(.PC_W(15), .DATA_W(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .bus    (bus),
        .pc     (pc),
        .retire (retire),
        .halted (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rom [0:32767];
    logic [15:0] env_mem [0:32767];
    logic [15:0] rom_q = 16'h0000;
    logic [15:0] env_a = 16'h0000;
    logic [15:0] env_d = 16'h0000;

    always_ff @(posedge clk) rom_q <= rom[bus.rom_addr];

    always_ff @(posedge clk) begin
        if (bus.reg_m_en) env_mem[env_a[14:0]] <= bus.data_out;
        if (bus.reg_a_en) env_a <= bus.data_out;
        if (bus.reg_d_en) env_d <= bus.data_out;
    end

    assign bus.rom_data = rom_q;
    assign bus.reg_a_in = env_a;
    assign bus.reg_d_in = env_d;
    assign bus.reg_m_in = env_mem[env_a[14:0]];

    int checks = 0;
    int errors = 0;
    logic [14:0] exp_pc = 15'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [15:0] ins, input logic [15:0] a,
                                            input logic [15:0] d, input logic [15:0] m);
        logic [15:0] x, y, r;
        x = ins[11] ? 16'h0000 : d;
        if (ins[10]) x = ~x;
        y = ins[9] ? 16'h0000 : (ins[12] ? m : a);
        if (ins[8]) y = ~y;
        r = ins[7] ? 16'(x + y) : (x & y);
        return ins[6] ? ~r : r;
    endfunction

    function automatic logic ref_take(input logic [2:0] j, input logic [15:0] val);
        int sv;
        sv = int'($signed(val));
        return (j[2] && sv < 0) || (j[1] && sv == 0) || (j[0] && sv > 0);
    endfunction

    // Executes one instruction at exp_pc: entered and left at a negedge while in FETCH.
    task automatic step(input logic [15:0] ins);
        logic [15:0] a0, d0, m0, out;
        logic        is_c, tk, ea, ed, em, hlt;
        logic [14:0] pc0, pcn;
        a0   = env_a;
        d0   = env_d;
        m0   = env_mem[a0[14:0]];
        pc0  = exp_pc;
        is_c = ins[15];
        out  = is_c ? ref_alu(ins, a0, d0, m0) : {1'b0, ins[14:0]};
        tk   = is_c && ref_take(ins[2:0], out);
        ea   = !is_c || ins[5];
        ed   = is_c && ins[4];
        em   = is_c && ins[3];
        pcn  = tk ? a0[14:0] : 15'(pc0 + 15'd1);
        hlt  = 1'b0;
`ifdef HACK_CPU_HALT_DETECT_EN
        hlt  = tk && (a0[14:0] == pc0);
`endif
        check("rom_addr", 32'(bus.rom_addr), 32'(pc0));
        rom[pc0] = ins;
        run = 1'b1;
        @(negedge clk);
        check("retire", 32'(retire), 32'd1);
        check("data_out", 32'(bus.data_out), 32'(out));
        check("enables", 32'({bus.reg_a_en, bus.reg_d_en, bus.reg_m_en}), 32'({ea, ed, em}));
        @(negedge clk);
        check("pc", 32'(pc), 32'(pcn));
        check("reg_a", 32'(env_a), 32'(ea ? out : a0));
        check("reg_d", 32'(env_d), 32'(ed ? out : d0));
        check("mem", 32'(env_mem[a0[14:0]]), 32'(em ? out : m0));
        check("halted", 32'(halted), 32'(hlt));
        $display("step pc=%04h instr=%04h out=%04h en=%b%b%b next_pc=%04h",
                 pc0, ins, out, ea, ed, em, pcn);
        exp_pc = pcn;
    endtask

    initial begin
        logic [15:0] ins, outv;
        logic [15:0] a_saved;
        int          pulses;

        rst_n = 1'b0;
        run   = 1'b0;
        for (int i = 0; i < 32768; i++) begin
            rom[i] = 16'h0000;
            env_mem[i] = 16'($urandom);
        end
        repeat (2) @(negedge clk);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_en", 32'({bus.reg_a_en, bus.reg_d_en, bus.reg_m_en}), 32'd0);
        check("rst_data", 32'(bus.data_out), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;

        // Held off by run=0.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_pc", 32'(pc), 32'd0);
            check("idle_out", 32'({retire, bus.reg_a_en, bus.reg_d_en, bus.reg_m_en}), 32'd0);
        end

        // Directed program following the worked examples.
        step(16'h0005);
        step(16'hEC10);
        step(16'h0007);
        step(16'hEC10);
        step(16'h0003);
        step(16'hE7C8);
        check("mem3", 32'(env_mem[3]), 32'h8);
        step(16'h000A);
        step(16'hEC10);
        step(16'h0004);
        step(16'hE308);
        step(16'hFCA8);
        check("mem4", 32'(env_mem[4]), 32'h9);
        check("a_after_am", 32'(env_a), 32'h9);
        step(16'h0020);
        step(16'hEA90);
        step(16'hE301);
        step(16'hEFD0);
        step(16'hE301);
        check("jgt_taken", 32'(pc), 32'h20);

        // PC wrap from the top of the address space.
        step(16'h7FFF);
        step(16'hEA87);
        step(16'hEA90);
        check("pc_wrap", 32'(pc), 32'h0);

        // Random instructions; self-jumps are suppressed so the run keeps going.
        for (int i = 0; i < 60; i++) begin
            ins = 16'($urandom);
            if (ins[15]) begin
                outv = ref_alu(ins, env_a, env_d, env_mem[env_a[14:0]]);
                if (ref_take(ins[2:0], outv) && env_a[14:0] == exp_pc) ins[2:0] = 3'b000;
            end
            step(ins);
        end

        // Asynchronous reset in the middle of EXEC must cancel the pending write.
        rom[exp_pc] = 16'h1234;
        run = 1'b1;
        @(negedge clk);
        check("mid_exec_en", 32'(bus.reg_a_en), 32'd1);
        a_saved = env_a;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("async_en", 32'({retire, bus.reg_a_en, bus.reg_d_en, bus.reg_m_en}), 32'd0);
        check("async_pc", 32'(pc), 32'd0);
        @(negedge clk);
        check("no_write", 32'(env_a), 32'(a_saved));
        rst_n = 1'b1;
        exp_pc = 15'd0;
        $display("async reset mid-EXEC, A held at %04h", a_saved);

        // Self-jump at pc=2.
        step(16'hEA90);
        step(16'h0002);
        step(16'hEA87);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (retire) pulses++;
            check("loop_pc", 32'(pc), 32'd2);
`ifdef HACK_CPU_HALT_DETECT_EN
            check("halt_flag", 32'(halted), 32'd1);
            check("halt_quiet", 32'({retire, bus.reg_a_en, bus.reg_d_en, bus.reg_m_en}), 32'd0);
`endif
        end
`ifdef HACK_CPU_HALT_DETECT_EN
        check("halt_pulses", 32'(pulses), 32'd0);
`else
        check("loop_pulses", 32'(pulses), 32'd4);
        check("no_halt", 32'(halted), 32'd0);
`endif
        $display("self-jump: %0d retire pulses in 8 cycles", pulses);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
